// File: rtl/data_sync_src_pkg.sv
// Shared definitions for the bus MUX synchronizer source/destination pair.
// Handshake state encoding and default synchronizer depth.
package data_sync_src_pkg;

    localparam int DEF_NUM_STAGES = 2;
    localparam int DEF_BUS_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_e;

endpackage

// File: rtl/data_sync_src_bit_sync.sv
// Multi-flop single-bit synchronizer, synchronous active-low reset to 0.
// Shared by the source ack path and the destination request path.
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [NUM_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_src.sv
// Source-side front end: holds a word on Unsync_Bus and runs a
// 4-phase Enable/ack handshake with the destination-side synchronizer.
module data_sync_src
    import data_sync_src_pkg::*;
#(
    parameter int NUM_STAGES       = DEF_NUM_STAGES,
    parameter int UNSYNC_BUS_WIDTH = DEF_BUS_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [UNSYNC_BUS_WIDTH-1:0] In_Data,
    input  logic                        In_Valid,
    output logic                        In_Ready,
    output logic [UNSYNC_BUS_WIDTH-1:0] Unsync_Bus,
    output logic                        Enable,
    input  logic                        Ack_Async,
    output logic                        Done,
    output logic                        Ack_Err
);

    state_e                      state_q;
    logic [UNSYNC_BUS_WIDTH-1:0] bus_q;
    logic                        enable_q;
    logic                        done_q;
    logic                        err_q;
    logic                        ack_s;
    logic                        accept;

    bit_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (Ack_Async),
        .q_o (ack_s)
    );

    // Ready only in IDLE once the previous ack has fully drained.
    assign In_Ready = rst && (state_q == IDLE) && !ack_s;
    assign accept   = In_Valid && In_Ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            bus_q    <= '0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ack_s) begin
                        err_q <= 1'b1;
                    end else if (accept) begin
                        bus_q    <= In_Data;
                        enable_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        enable_q <= 1'b0;
                        state_q  <= REL;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    enable_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign Unsync_Bus = bus_q;
    assign Enable     = enable_q;
    assign Done       = done_q;
    assign Ack_Err    = err_q;

endmodule

// File: tb/tb_data_sync_src.sv
// Directed bench for data_sync_src; the bench plays the destination
// side, answering Enable with a delayed Ack_Async level.
module tb_data_sync_src;

    logic       clk;
    logic       rst;
    logic [7:0] In_Data;
    logic       In_Valid;
    logic       In_Ready;
    logic [7:0] Unsync_Bus;
    logic       Enable;
    logic       Ack_Async;
    logic       Done;
    logic       Ack_Err;

    int n_checks = 0;
    int n_fails  = 0;
    int en_rises = 0;
    int done_cnt = 0;
    logic en_prev = 1'b0;

    data_sync_src #(
        .NUM_STAGES       (2),
        .UNSYNC_BUS_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .In_Data    (In_Data),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Unsync_Bus (Unsync_Bus),
        .Enable     (Enable),
        .Ack_Async  (Ack_Async),
        .Done       (Done),
        .Ack_Err    (Ack_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Enable && !en_prev) en_rises++;
        if (Done) done_cnt++;
        en_prev = Enable;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after the accept edge; returns just after the Done edge.
    task automatic xfer_dest(input logic [7:0] exp);
        chk("en_rise", Enable, 1);
        chk("bus_acc", Unsync_Bus, exp);
        chk("rdy_req", In_Ready, 0);
        repeat (3) begin
            tick();
            chk("en_hold", Enable, 1);
            chk("bus_req", Unsync_Bus, exp);
        end
        Ack_Async = 1'b1;
        tick();
        tick();
        chk("en_before_sync", Enable, 1);
        tick();
        chk("en_fall", Enable, 0);
        chk("bus_rel", Unsync_Bus, exp);
        chk("rdy_rel", In_Ready, 0);
        repeat (3) tick();
        Ack_Async = 1'b0;
        tick();
        tick();
        chk("done_early", Done, 0);
        chk("rdy_rel2", In_Ready, 0);
        tick();
        chk("done_pulse", Done, 1);
        chk("bus_done", Unsync_Bus, exp);
    endtask

    logic [7:0] words [4];
    int er0;
    int dc0;

    initial begin
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h04;
        words[3] = 8'h08;
        rst       = 1'b0;
        In_Valid  = 1'b1;
        In_Data   = 8'hFF;
        Ack_Async = 1'b1;

        // Reset with hostile inputs
        tick();
        tick();
        chk("rst_bus", Unsync_Bus, 8'h00);
        chk("rst_en", Enable, 0);
        chk("rst_done", Done, 0);
        chk("rst_err", Ack_Err, 0);
        chk("rst_rdy", In_Ready, 0);
        In_Valid  = 1'b0;
        Ack_Async = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("idle_rdy", In_Ready, 1);
        chk("idle_en", Enable, 0);

        // Single transfer
        In_Data  = 8'hA5;
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        xfer_dest(8'hA5);
        tick();
        chk("single_done_off", Done, 0);
        chk("single_rdy", In_Ready, 1);
        chk("single_bus_keep", Unsync_Bus, 8'hA5);

        // Backpressure: 3C held valid for the whole A5 round trip
        In_Data  = 8'hA5;
        In_Valid = 1'b1;
        tick();
        In_Data = 8'h3C;
        er0 = en_rises;
        xfer_dest(8'hA5);
        chk("bp_no_extra_en", en_rises - er0, 0);
        tick();
        chk("bp_accept_en", Enable, 1);
        chk("bp_accept_bus", Unsync_Bus, 8'h3C);
        chk("bp_done_off", Done, 0);
        In_Valid = 1'b0;
        xfer_dest(8'h3C);
        tick();

        // Back-to-back words with valid held
        er0 = en_rises;
        dc0 = done_cnt;
        In_Data  = words[0];
        In_Valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) In_Data = words[i+1];
            else In_Valid = 1'b0;
            xfer_dest(words[i]);
            tick();
        end
        chk("b2b_en_idle", Enable, 0);
        chk("b2b_bus_last", Unsync_Bus, 8'h08);
        chk("b2b_en_rises", en_rises - er0, 4);
        chk("b2b_dones", done_cnt - dc0, 4);

        // Spurious ack while idle
        er0 = en_rises;
        Ack_Async = 1'b1;
        tick();
        chk("sp_rdy_pre", In_Ready, 1);
        tick();
        chk("sp_rdy_low", In_Ready, 0);
        tick();
        chk("sp_err_set", Ack_Err, 1);
        tick();
        Ack_Async = 1'b0;
        tick();
        chk("sp_rdy_low2", In_Ready, 0);
        tick();
        chk("sp_rdy_back", In_Ready, 1);
        repeat (3) tick();
        chk("sp_err_sticky", Ack_Err, 1);
        chk("sp_no_en", en_rises - er0, 0);
        chk("sp_en_low", Enable, 0);

        // Reset in the middle of a request
        In_Data  = 8'h5A;
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        chk("mr_en", Enable, 1);
        chk("mr_bus", Unsync_Bus, 8'h5A);
        rst = 1'b0;
        tick();
        chk("mr_en_clr", Enable, 0);
        chk("mr_bus_clr", Unsync_Bus, 8'h00);
        chk("mr_err_clr", Ack_Err, 0);
        chk("mr_rdy_rst", In_Ready, 0);
        rst = 1'b1;
        tick();
        chk("mr_rdy_idle", In_Ready, 1);
        In_Data  = 8'hC3;
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        xfer_dest(8'hC3);
        tick();
        chk("mr_done_off", Done, 0);
        chk("mr_rdy_end", In_Ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
